// File: rtl/mux_sel_pkg.sv
// Shared types and helpers for the 4:1 mux select arbiter.
// Channel index maps straight onto the mux select pins: s0 = index bit1, s1 = index bit0.
package mux_sel_pkg;
  localparam int NCH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Returns {s0, s1} for a channel index (0/1/2/3 -> a/b/c/d).
  function automatic logic [1:0] idx_to_sel(input logic [1:0] idx);
    return {idx[1], idx[0]};
  endfunction

  function automatic logic [NCH-1:0] idx_to_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction
endpackage

// File: rtl/mux_sel_arb_rr_pick.sv
// Circular priority pick: first requesting channel at or after ptr, order 0->1->2->3->0.
// Purely combinational, zero latency; no flow control of its own.
module rr_pick
  import mux_sel_pkg::*;
(
  input  logic [NCH-1:0] req,
  input  logic [1:0]     ptr,
  output logic [1:0]     idx,
  output logic           any
);

  // Walk from the farthest offset back to ptr so the nearest requester wins.
  always_comb begin
    idx = ptr;
    any = 1'b0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) begin
        idx = ptr + 2'(k);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_sel_arb.sv
// Round-robin 4:1 mux select arbiter; all outputs registered, grant appears 1 cycle after request.
// ready=0 freezes a grant indefinitely; release after BURST handshakes or when the owner drops req.
module mux_sel_arb
  import mux_sel_pkg::*;
#(
  parameter int BURST = 4
)
(
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] req,
  input  logic           ready,
  output logic           s0,
  output logic           s1,
  output logic [NCH-1:0] grant,
  output logic           valid
);

  localparam logic [3:0] BURST_C = 4'(BURST);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic [1:0] r_ptr;

  logic [1:0] w_idx;
  logic [1:0] w_cur;
  logic       w_any;
  logic       w_hs;
  logic       w_last;
  logic       w_drop;

  rr_pick u_pick (
    .req (req),
    .ptr (r_ptr),
    .idx (w_idx),
    .any (w_any)
  );

  // The select flops double as the current-owner register.
  assign w_cur  = {s0, s1};
  assign w_hs   = valid && ready;
  assign w_drop = !req[w_cur];
  assign w_last = w_hs && ((r_cnt + 4'd1) == BURST_C);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_ptr   <= 2'd0;
      valid   <= 1'b0;
      grant   <= '0;
      s0      <= 1'b0;
      s1      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state  <= GRANT;
            r_cnt    <= 4'd0;
            valid    <= 1'b1;
            grant    <= idx_to_onehot(w_idx);
            {s0, s1} <= idx_to_sel(w_idx);
          end
        end
        GRANT: begin
          // Owner dropping its request wins over backpressure; selects hold through IDLE.
          if (w_drop || w_last) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_ptr   <= w_cur + 2'd1;
            valid   <= 1'b0;
            grant   <= '0;
          end else if (w_hs) begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_sel_arb.sv
// Scoreboarded bench: BURST=4 and BURST=1 arbiters share stimulus, each with its own expectation queue.
// Directed vectors push per-cycle expected outputs; a negedge monitor pops and compares.
module tb_mux_sel_arb;

  typedef struct {
    int         cyc;
    logic       v;
    logic [3:0] g;
    logic [1:0] s;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       ready;

  logic       a_s0, a_s1, a_valid;
  logic [3:0] a_grant;
  logic       b_s0, b_s1, b_valid;
  logic [3:0] b_grant;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   tmo = 1'b0;
  bit   tmo_rep = 1'b0;
  exp_t q4[$];
  exp_t q1[$];

  mux_sel_arb #(.BURST(4)) u4 (
    .clk(clk), .rst(rst), .req(req), .ready(ready),
    .s0(a_s0), .s1(a_s1), .grant(a_grant), .valid(a_valid)
  );

  mux_sel_arb #(.BURST(1)) u1 (
    .clk(clk), .rst(rst), .req(req), .ready(ready),
    .s0(b_s0), .s1(b_s1), .grant(b_grant), .valid(b_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input exp_t e, input logic v, input logic [3:0] g,
                     input logic sa, input logic sb);
    checks++;
    if (v !== e.v || g !== e.g || {sa, sb} !== e.s) begin
      errors++;
      $display("FAIL %s cyc=%0d got valid=%b grant=%b sel=%b%b exp valid=%b grant=%b sel=%b",
               nm, e.cyc, v, g, sa, sb, e.v, e.g, e.s);
    end
  endtask

  task automatic inv(input string nm, input logic v, input logic [3:0] g,
                     input logic sa, input logic sb);
    logic [3:0] one;
    one = 4'b0001 << {sa, sb};
    checks++;
    if ((v && g !== one) || (!v && g !== 4'b0000)) begin
      errors++;
      $display("FAIL %s_onehot cyc=%0d got valid=%b grant=%b sel=%b%b", nm, cyc, v, g, sa, sb);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (q4.size() != 0 && q4[0].cyc <= cyc) begin
      e = q4.pop_front();
      chk("burst4", e, a_valid, a_grant, a_s0, a_s1);
    end
    while (q1.size() != 0 && q1[0].cyc <= cyc) begin
      e = q1.pop_front();
      chk("burst1", e, b_valid, b_grant, b_s0, b_s1);
    end
    if (cyc > 2) begin
      inv("burst4", a_valid, a_grant, a_s0, a_s1);
      inv("burst1", b_valid, b_grant, b_s0, b_s1);
    end
    if (tmo && !tmo_rep) begin
      tmo_rep = 1'b1;
      checks++;
      errors++;
      $display("FAIL drain_timeout got q4=%0d q1=%0d pending, exp 0", q4.size(), q1.size());
    end
  end

  task automatic drive(input logic r, input logic [3:0] rq, input logic rdy);
    @(posedge clk);
    #1;
    rst   = r;
    req   = rq;
    ready = rdy;
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
  task automatic step(input logic r, input logic [3:0] rq, input logic rdy,
                      input logic [3:0] g4, input logic [1:0] s4,
                      input logic [3:0] g1, input logic [1:0] s1x);
    exp_t e;
    drive(r, rq, rdy);
    e.cyc = cyc + 1;
    e.v = (g4 != 4'b0000); e.g = g4; e.s = s4;
    q4.push_back(e);
    e.v = (g1 != 4'b0000); e.g = g1; e.s = s1x;
    q1.push_back(e);
  endtask

  initial begin
    rst = 1'b1; req = 4'b0000; ready = 1'b0;
    repeat (2) @(posedge clk);

    // Reset held with everything requesting, then release: ch0 first.
    step(1, 4'b1111, 1, 4'b0000, 2'd0, 4'b0000, 2'd0);
    step(1, 4'b1111, 1, 4'b0000, 2'd0, 4'b0000, 2'd0);
    step(0, 4'b1111, 1, 4'b0001, 2'd0, 4'b0001, 2'd0);
    step(0, 4'b1111, 1, 4'b0001, 2'd0, 4'b0000, 2'd0);
    step(0, 4'b1111, 1, 4'b0001, 2'd0, 4'b0010, 2'd1);
    step(0, 4'b1111, 1, 4'b0001, 2'd0, 4'b0000, 2'd1);
    step(0, 4'b1111, 1, 4'b0000, 2'd0, 4'b0100, 2'd2);
    step(0, 4'b1111, 1, 4'b0010, 2'd1, 4'b0000, 2'd2);
    step(0, 4'b1111, 1, 4'b0010, 2'd1, 4'b1000, 2'd3);
    step(0, 4'b1111, 1, 4'b0010, 2'd1, 4'b0000, 2'd3);
    step(0, 4'b1111, 1, 4'b0010, 2'd1, 4'b0001, 2'd0);
    step(1, 4'b0000, 0, 4'b0000, 2'd0, 4'b0000, 2'd0);

    // Single requester ch1: burst of 4, one idle cycle, re-grant.
    step(0, 4'b0010, 1, 4'b0010, 2'd1, 4'b0010, 2'd1);
    step(0, 4'b0010, 1, 4'b0010, 2'd1, 4'b0000, 2'd1);
    step(0, 4'b0010, 1, 4'b0010, 2'd1, 4'b0010, 2'd1);
    step(0, 4'b0010, 1, 4'b0010, 2'd1, 4'b0000, 2'd1);
    step(0, 4'b0010, 1, 4'b0000, 2'd1, 4'b0010, 2'd1);
    step(0, 4'b0010, 1, 4'b0010, 2'd1, 4'b0000, 2'd1);
    step(1, 4'b0000, 0, 4'b0000, 2'd0, 4'b0000, 2'd0);

    // ch2 under 10 cycles of backpressure, then exactly 4 handshakes.
    step(0, 4'b0100, 0, 4'b0100, 2'd2, 4'b0100, 2'd2);
    repeat (10) step(0, 4'b0100, 0, 4'b0100, 2'd2, 4'b0100, 2'd2);
    step(0, 4'b0100, 1, 4'b0100, 2'd2, 4'b0000, 2'd2);
    step(0, 4'b0100, 1, 4'b0100, 2'd2, 4'b0100, 2'd2);
    step(0, 4'b0100, 1, 4'b0100, 2'd2, 4'b0000, 2'd2);
    step(0, 4'b0100, 1, 4'b0000, 2'd2, 4'b0100, 2'd2);
    step(0, 4'b0000, 0, 4'b0000, 2'd2, 4'b0000, 2'd2);
    step(1, 4'b0000, 0, 4'b0000, 2'd0, 4'b0000, 2'd0);

    // Owner drops request while stalled: release, then ch3 next.
    step(0, 4'b0100, 0, 4'b0100, 2'd2, 4'b0100, 2'd2);
    step(0, 4'b1000, 0, 4'b0000, 2'd2, 4'b0000, 2'd2);
    step(0, 4'b1000, 0, 4'b1000, 2'd3, 4'b1000, 2'd3);
    step(1, 4'b0000, 0, 4'b0000, 2'd0, 4'b0000, 2'd0);

    // Reset mid-burst (cnt=2) with a coincident handshake; ptr restarts at 0.
    step(0, 4'b0100, 0, 4'b0100, 2'd2, 4'b0100, 2'd2);
    step(0, 4'b0100, 1, 4'b0100, 2'd2, 4'b0000, 2'd2);
    step(0, 4'b0100, 1, 4'b0100, 2'd2, 4'b0100, 2'd2);
    step(1, 4'b0100, 1, 4'b0000, 2'd0, 4'b0000, 2'd0);
    step(0, 4'b0011, 1, 4'b0001, 2'd0, 4'b0001, 2'd0);
    step(0, 4'b0011, 1, 4'b0001, 2'd0, 4'b0000, 2'd0);

    drive(0, 4'b0000, 0);
    for (int i = 0; i < 20 && (q4.size() != 0 || q1.size() != 0); i++) @(posedge clk);
    if (q4.size() != 0 || q1.size() != 0) tmo = 1'b1;
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
